// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: protocol byte values, parser states and the
// queued event record used by the key event queue and its FIFO.
package ps2_pkg;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;
   localparam logic [7:0] PS2_AA = 8'hAA;
   localparam logic [7:0] PS2_FA = 8'hFA;
   localparam logic [7:0] PS2_EE = 8'hEE;
   localparam logic [7:0] PS2_FE = 8'hFE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } parser_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   // Self-test/ack/echo/resend and buffer-error bytes never start a key event.
   function automatic logic isNoiseByte(input logic [7:0] b);
      return (b == PS2_AA) || (b == PS2_FA) || (b == PS2_EE) ||
             (b == PS2_FE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   function automatic logic isPrefixByte(input logic [7:0] b);
      return (b == PS2_E0) || (b == PS2_F0);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO for decoded key events; a read of an empty
// queue is ignored and a full queue accepts a write only alongside a read.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_wrEn,
   input  logic [WIDTH-1:0]           i_wrData,
   input  logic                       i_rdEn,
   output logic [WIDTH-1:0]           o_rdData,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_rdAccept;
   logic             w_wrAccept;

   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == CW'(DEPTH));
   assign w_rdAccept = i_rdEn && !o_empty;
   assign w_wrAccept = i_wrEn && (!o_full || w_rdAccept);
   assign o_count    = r_count;
   assign o_rdData   = o_empty ? '0 : r_mem[r_rdPtr];

   always_ff @(posedge i_clk) begin
      if (w_wrAccept) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_wrAccept) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_rdAccept) r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_wrAccept, w_rdAccept})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode parser: folds E0/F0 prefixes into make/break events, queues
// them for software, and tracks held state for a small set of watched keys.
module ps2_key_event_queue #(
   parameter int                     FIFO_DEPTH     = 8,
   parameter int                     PREFIX_TIMEOUT = 50_000_000,
   parameter int                     NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0]  WATCH_CODES    = {9'h075, 9'h072, 9'h06B, 9'h074}
) (
   input  logic                            CLOCK_50,
   input  logic                            reset,
   input  logic [7:0]                      rx_data,
   input  logic                            rx_data_en,
   input  logic                            evt_rd,
   output logic                            evt_valid,
   output logic [7:0]                      evt_code,
   output logic                            evt_ext,
   output logic                            evt_break,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
   output logic                            overflow,
   output logic [NUM_KEYS-1:0]             key_held,
   output logic [7:0]                      last_code
);

   import ps2_pkg::*;

   localparam int TW = $clog2(PREFIX_TIMEOUT+1);

   parser_state_t r_state;
   parser_state_t w_nextState;
   logic [TW-1:0] r_timer;
   logic          w_timeout;
   logic          w_evtDone;
   key_event_t    w_evt;
   key_event_t    w_head;
   logic          w_full;
   logic          w_empty;
   logic          r_overflow;
   logic [NUM_KEYS-1:0] r_keyHeld;
   logic [7:0]    r_lastCode;

   assign w_timeout = (r_state != ST_IDLE) && !rx_data_en &&
                      (r_timer == TW'(PREFIX_TIMEOUT-1));

   always_comb begin
      w_nextState = r_state;
      w_evtDone   = 1'b0;
      w_evt       = '{ext: 1'b0, brk: 1'b0, code: rx_data};
      if (rx_data_en) begin
         case (r_state)
            ST_IDLE: begin
               if (rx_data == PS2_E0)      w_nextState = ST_EXT;
               else if (rx_data == PS2_F0) w_nextState = ST_BRK;
               else if (!isNoiseByte(rx_data)) w_evtDone = 1'b1;
            end
            ST_EXT: begin
               if (rx_data == PS2_F0) w_nextState = ST_EXT_BRK;
               else if (rx_data != PS2_E0) begin
                  w_evtDone   = 1'b1;
                  w_evt.ext   = 1'b1;
                  w_nextState = ST_IDLE;
               end
            end
            ST_BRK: begin
               w_nextState = ST_IDLE;
               w_evtDone   = !isPrefixByte(rx_data);
               w_evt.brk   = 1'b1;
            end
            default: begin
               w_nextState = ST_IDLE;
               w_evtDone   = !isPrefixByte(rx_data);
               w_evt.ext   = 1'b1;
               w_evt.brk   = 1'b1;
            end
         endcase
      end else if (w_timeout) begin
         w_nextState = ST_IDLE;
      end
   end

   // The timer only runs while a prefix is pending and restarts on every byte.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_nextState;
         if (rx_data_en || (w_nextState == ST_IDLE)) r_timer <= '0;
         else                                        r_timer <= r_timer + TW'(1);
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(key_event_t))
   ) u_fifo (
      .i_clk    (CLOCK_50),
      .i_rst    (reset),
      .i_wrEn   (w_evtDone),
      .i_wrData (w_evt),
      .i_rdEn   (evt_rd),
      .o_rdData (w_head),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (evt_count)
   );

   // A full queue is never empty, so a concurrent evt_rd always frees a slot.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
         r_keyHeld  <= '0;
         r_lastCode <= 8'h00;
      end else if (w_evtDone) begin
         if (w_full && !evt_rd) r_overflow <= 1'b1;
         r_lastCode <= w_evt.code;
         for (int i = 0; i < NUM_KEYS; i++) begin
            if ({w_evt.ext, w_evt.code} == WATCH_CODES[i*9 +: 9]) r_keyHeld[i] <= !w_evt.brk;
         end
      end
   end

   assign evt_valid = !w_empty;
   assign evt_code  = w_head.code;
   assign evt_ext   = w_head.ext;
   assign evt_break = w_head.brk;
   assign overflow  = r_overflow;
   assign key_held  = r_keyHeld;
   assign last_code = r_lastCode;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue with a 4-deep queue and a short prefix
// timeout; the arrow watch entries carry ext=1 since those keys arrive behind E0.
module tb_ps2_key_event_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_data_en = 1'b0;
   logic          evt_rd   = 1'b0;
   logic          evt_valid;
   logic [7:0]    evt_code;
   logic          evt_ext;
   logic          evt_break;
   logic [CW-1:0] evt_count;
   logic          overflow;
   logic [3:0]    key_held;
   logic [7:0]    last_code;

   int         checkCount = 0;
   int         passCount  = 0;
   logic [9:0] sbQ [$];
   logic       expOverflow = 1'b0;

   ps2_key_event_queue #(
      .FIFO_DEPTH     (DEPTH),
      .PREFIX_TIMEOUT (16),
      .NUM_KEYS       (4),
      .WATCH_CODES    ({9'h174, 9'h16B, 9'h072, 9'h175})
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_data_en (rx_data_en),
      .evt_rd     (evt_rd),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_break  (evt_break),
      .evt_count  (evt_count),
      .overflow   (overflow),
      .key_held   (key_held),
      .last_code  (last_code)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Drives one cycle (optionally a byte and/or a pop) starting just after a negedge;
   // the scoreboard head is compared before the pop and expected events are queued.
   task automatic applyStimulus(input logic [7:0] b, input logic strobe, input logic rd,
                                input logic hasEvt, input logic ext, input logic brk);
      logic rdAccepted;
      logic doPush;
      rdAccepted = 1'b0;
      if (rd) begin
         checkOutput("evt_valid_before_rd", evt_valid, sbQ.size() != 0);
         if (sbQ.size() != 0) begin
            checkOutput("head", {evt_ext, evt_break, evt_code}, sbQ[0]);
            rdAccepted = 1'b1;
         end else begin
            checkOutput("head_empty", {evt_ext, evt_break, evt_code}, 0);
         end
      end
      rx_data    = b;
      rx_data_en = strobe;
      evt_rd     = rd;
      doPush = strobe && hasEvt && ((sbQ.size() < DEPTH) || rdAccepted);
      if (strobe && hasEvt && !doPush) expOverflow = 1'b1;
      if (rdAccepted) void'(sbQ.pop_front());
      if (doPush) sbQ.push_back({ext, brk, b});
      @(negedge CLOCK_50);
      rx_data_en = 1'b0;
      evt_rd     = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sendEvent(input logic [7:0] b, input logic ext, input logic brk);
      applyStimulus(b, 1'b1, 1'b0, 1'b1, ext, brk);
   endtask

   task automatic checkQueueState(input string tag);
      checkOutput({tag, "_count"}, evt_count, sbQ.size());
      checkOutput({tag, "_valid"}, evt_valid, sbQ.size() != 0);
      checkOutput({tag, "_overflow"}, overflow, expOverflow);
   endtask

   task automatic drain(input string tag);
      while (sbQ.size() != 0) applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkQueueState(tag);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, evt_valid, 0);
      checkOutput({tag, "_count"}, evt_count, 0);
      checkOutput({tag, "_overflow"}, overflow, 0);
      checkOutput({tag, "_key_held"}, key_held, 0);
      checkOutput({tag, "_last_code"}, last_code, 0);
      checkOutput({tag, "_head"}, {evt_ext, evt_break, evt_code}, 0);
   endtask

   task automatic doReset(input string tag);
      reset = 1'b1;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      sbQ.delete();
      expOverflow = 1'b0;
      checkResetState(tag);
   endtask

   initial begin
      doReset("reset");

      // Plain make then break of the same key, with one-cycle write latency.
      sendEvent(8'h1C, 1'b0, 1'b0);
      checkQueueState("make_latency");
      sendByte(8'hF0);
      sendEvent(8'h1C, 1'b0, 1'b1);
      checkQueueState("make_break");
      checkOutput("last_code_1C", last_code, 8'h1C);
      drain("make_break_drain");

      // Extended arrow press/release and a non-extended watched key.
      sendByte(8'hE0);
      sendEvent(8'h75, 1'b1, 1'b0);
      checkOutput("held_up_arrow", key_held, 4'b0001);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendEvent(8'h75, 1'b1, 1'b1);
      checkOutput("released_up_arrow", key_held, 4'b0000);
      drain("arrow_drain");
      sendEvent(8'h72, 1'b0, 1'b0);
      sendEvent(8'h72, 1'b0, 1'b0);
      checkOutput("held_plain_72", key_held, 4'b0010);
      sendByte(8'hE0);
      sendEvent(8'h72, 1'b1, 1'b0);
      checkOutput("ext_72_no_match", key_held, 4'b0010);
      sendByte(8'hF0);
      sendEvent(8'h72, 1'b0, 1'b1);
      checkOutput("released_plain_72", key_held, 4'b0000);
      drain("watch_drain");

      // Noise bytes and a broken prefix pair leave the parser idle.
      sendByte(8'hAA);
      sendByte(8'hFA);
      sendByte(8'hF0);
      sendByte(8'hE0);
      checkQueueState("noise");
      sendEvent(8'h29, 1'b0, 1'b0);
      checkQueueState("after_noise");
      drain("noise_drain");

      // Prefix survives a short gap but expires after the timeout.
      sendByte(8'hE0);
      repeat (10) @(negedge CLOCK_50);
      sendEvent(8'h1C, 1'b1, 1'b0);
      sendByte(8'hE0);
      repeat (20) @(negedge CLOCK_50);
      sendEvent(8'h1C, 1'b0, 1'b0);
      checkQueueState("timeout");
      drain("timeout_drain");

      // Overflow on a full queue, then a simultaneous read and write while full.
      sendEvent(8'h16, 1'b0, 1'b0);
      sendEvent(8'h1E, 1'b0, 1'b0);
      sendEvent(8'h26, 1'b0, 1'b0);
      sendEvent(8'h25, 1'b0, 1'b0);
      sendEvent(8'h2E, 1'b0, 1'b0);
      checkQueueState("overflow");
      checkOutput("overflow_head", {evt_ext, evt_break, evt_code}, 10'h016);
      checkOutput("overflow_last_code", last_code, 8'h2E);
      applyStimulus(8'h36, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkQueueState("full_rd_wr");
      drain("overflow_drain");

      // Read with write into an empty queue, then a read of an empty queue.
      applyStimulus(8'h45, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkQueueState("empty_rd_wr");
      drain("empty_rd_wr_drain");
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkQueueState("empty_rd");

      // Reset clears sticky overflow; an async pulse mid-prefix drops the partial event.
      doReset("reset2");
      sendByte(8'hF0);
      #3 reset = 1'b1;
      #2 checkResetState("async_reset");
      @(negedge CLOCK_50);
      reset = 1'b0;
      sbQ.delete();
      expOverflow = 1'b0;
      sendEvent(8'h1C, 1'b0, 1'b0);
      checkQueueState("after_reset");
      drain("after_reset_drain");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
